// File: rtl/pipeline_controller.sv
// ---------------------------------------------------------------------------
// pipeline_controller
//
// Central hazard/flush/sleep controller for a short in-order pipeline. Tracks
// in-flight register writes in a small shifting scoreboard, raises per-cause
// stall bits, runs a two-cycle flush after taken branches, parks the core
// while sleeping, and counts stalled cycles.
//
// Parameters
//   SB_DEPTH : scoreboard entries, one per stage past decode
//              ([0] execute, [1] memory access, [2] writeback). Must be >= 2.
//   CNT_W    : width of the saturating stall-cycle counter.
//
// Ports
//   clk          in   sole clock, all state updates on posedge
//   rst          in   synchronous, active-high reset
//   dec_valid    in   decode stage holds a valid instruction
//   dec_src_a/b  in   decode source register numbers (3 bits each)
//   dec_use_a/b  in   corresponding source is a register read
//   dec_dst      in   decode destination register
//   dec_dst_wr   in   instruction writes dec_dst
//   dec_is_load  in   result is only available after memory access
//   br_taken     in   execute-stage branch resolved taken
//   slp          in   SLP instruction in execute
//   wake         in   wake / interrupt request
//   mem_busy     in   data memory not ready
//   stall_out    out  per-cause stall vector:
//                     [0] RAW, [1] load-use, [2] sleep, [3] mem busy, [7:4] 0
//   clear_out    out  flush request (registered, 1 cycle after br_taken)
//   fetch_hold   out  freeze PC / fetch
//   stall_count  out  number of cycles with any stall bit set (saturating)
// ---------------------------------------------------------------------------
module pipeline_controller #(
  parameter int SB_DEPTH = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  input  logic [2:0]       dec_src_a,
  input  logic [2:0]       dec_src_b,
  input  logic             dec_use_a,
  input  logic             dec_use_b,
  input  logic [2:0]       dec_dst,
  input  logic             dec_dst_wr,
  input  logic             dec_is_load,
  input  logic             br_taken,
  input  logic             slp,
  input  logic             wake,
  input  logic             mem_busy,
  output logic [7:0]       stall_out,
  output logic             clear_out,
  output logic             fetch_hold,
  output logic [CNT_W-1:0] stall_count
);

  // Flush FSM encoding.
  localparam logic [1:0] FL_IDLE = 2'd0;
  localparam logic [1:0] FL_1    = 2'd1;
  localparam logic [1:0] FL_2    = 2'd2;

  // Sleep FSM encoding.
  localparam logic [0:0] SL_RUN   = 1'b0;
  localparam logic [0:0] SL_SLEEP = 1'b1;

  typedef struct packed {
    logic       valid;
    logic [2:0] dst;
    logic       is_load;
  } sb_entry_t;

  sb_entry_t        sb [SB_DEPTH];
  logic [1:0]       flush_q, flush_d;
  logic [0:0]       sleep_q, sleep_d;

  logic             raw_hit;
  logic             lu_hit;
  logic             any_stall;
  logic             issue;

  // -------------------------------------------------------------------------
  // Hazard detection. The last scoreboard entry is the writeback stage: its
  // register write lands on the same edge the dependent instruction issues,
  // so only the entries ahead of it can cause a hazard.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned and infers a latch.
    raw_hit = 1'b0;
    lu_hit  = 1'b0;
    for (int i = 0; i < SB_DEPTH - 1; i++) begin
      if (dec_valid && sb[i].valid &&
          ((dec_use_a && (sb[i].dst == dec_src_a)) ||
           (dec_use_b && (sb[i].dst == dec_src_b)))) begin
        if (sb[i].is_load) lu_hit  = 1'b1;
        else               raw_hit = 1'b1;
      end
    end
  end

  // A flush squashes the dependent instruction anyway, so hazard stalls are
  // masked while clear_out is high.
  assign clear_out  = (flush_q != FL_IDLE);
  assign stall_out  = {4'b0000,
                       mem_busy,
                       (sleep_q == SL_SLEEP),
                       lu_hit  & ~clear_out,
                       raw_hit & ~clear_out};
  assign any_stall  = |stall_out;
  assign fetch_hold = any_stall & ~clear_out;
  assign issue      = dec_valid & dec_dst_wr & ~any_stall & ~clear_out;

  // -------------------------------------------------------------------------
  // Scoreboard: shifts every cycle whether or not decode issues; a stalled
  // or flushed decode inserts a bubble at the head.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: only the valid bits are reset; dst/is_load are qualified by
      // valid, so resetting the payload would cost flops and buy nothing.
      for (int i = 0; i < SB_DEPTH; i++) sb[i].valid <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every entry
      // shifts from its pre-edge value, independent of statement order.
      sb[0].valid   <= issue;
      sb[0].dst     <= dec_dst;
      sb[0].is_load <= dec_is_load;
      for (int i = 1; i < SB_DEPTH; i++) sb[i] <= sb[i-1];
    end
  end

  // -------------------------------------------------------------------------
  // Flush FSM: a taken branch (re)starts a two-cycle clear window from any
  // state, so a branch during a flush extends it.
  // -------------------------------------------------------------------------
  always_comb begin
    flush_d = FL_IDLE;
    if (br_taken) begin
      flush_d = FL_1;
    end else begin
      case (flush_q)
        FL_1:    flush_d = FL_2;
        FL_2:    flush_d = FL_IDLE;
        default: flush_d = FL_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Sleep FSM: wake wins over a coincident slp; a slp being flushed away is
  // ignored.
  // -------------------------------------------------------------------------
  always_comb begin
    sleep_d = sleep_q;
    case (sleep_q)
      SL_RUN:   if (slp && !wake && !clear_out) sleep_d = SL_SLEEP;
      SL_SLEEP: if (wake)                       sleep_d = SL_RUN;
      default:                                  sleep_d = SL_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_q <= FL_IDLE;
      sleep_q <= SL_RUN;
    end else begin
      flush_q <= flush_d;
      sleep_q <= sleep_d;
    end
  end

  // -------------------------------------------------------------------------
  // Stall-cycle counter, saturating at all-ones.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (any_stall && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_controller.sv
// ---------------------------------------------------------------------------
// tb_pipeline_controller
//
// Directed-vector bench for pipeline_controller. The stimulus process drives
// one cycle at a time and queues the expected outputs for that cycle; an
// independent monitor pops the queue at every falling edge and compares.
// A second instance with a 4-bit counter shares all inputs to exercise
// saturation.
// ---------------------------------------------------------------------------
module tb_pipeline_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid;
  logic [2:0]  dec_src_a, dec_src_b, dec_dst;
  logic        dec_use_a, dec_use_b, dec_dst_wr, dec_is_load;
  logic        br_taken, slp, wake, mem_busy;

  logic [7:0]  stall_out;
  logic        clear_out, fetch_hold;
  logic [15:0] stall_count;

  logic [7:0]  sat_stall_out;
  logic        sat_clear_out, sat_fetch_hold;
  logic [3:0]  sat_count;

  always #5 clk = ~clk;

  pipeline_controller dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_src_a(dec_src_a), .dec_src_b(dec_src_b),
    .dec_use_a(dec_use_a), .dec_use_b(dec_use_b), .dec_dst(dec_dst),
    .dec_dst_wr(dec_dst_wr), .dec_is_load(dec_is_load),
    .br_taken(br_taken), .slp(slp), .wake(wake), .mem_busy(mem_busy),
    .stall_out(stall_out), .clear_out(clear_out), .fetch_hold(fetch_hold),
    .stall_count(stall_count)
  );

  pipeline_controller #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_src_a(dec_src_a), .dec_src_b(dec_src_b),
    .dec_use_a(dec_use_a), .dec_use_b(dec_use_b), .dec_dst(dec_dst),
    .dec_dst_wr(dec_dst_wr), .dec_is_load(dec_is_load),
    .br_taken(br_taken), .slp(slp), .wake(wake), .mem_busy(mem_busy),
    .stall_out(sat_stall_out), .clear_out(sat_clear_out),
    .fetch_hold(sat_fetch_hold), .stall_count(sat_count)
  );

  // ---------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------
  typedef enum {K_OUT, K_CNT, K_SAT} kind_e;

  typedef struct {
    int          cyc;
    string       name;
    kind_e       kind;
    logic [7:0]  stall;
    logic        clear;
    logic        hold;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h",
               name, cyc, act, exp);
    end
  endtask

  task automatic push(input string name, input kind_e kind,
                      input logic [7:0] s, input logic c, input logic h,
                      input logic [15:0] n);
    exp_t e;
    e.cyc   = cyc;
    e.name  = name;
    e.kind  = kind;
    e.stall = s;
    e.clear = c;
    e.hold  = h;
    e.cnt   = n;
    exp_q.push_back(e);
  endtask

  task automatic exp_out(input string name, input logic [7:0] s,
                         input logic c, input logic h);
    push(name, K_OUT, s, c, h, 16'd0);
  endtask

  task automatic exp_cnt(input string name, input logic [15:0] n);
    push(name, K_CNT, 8'h00, 1'b0, 1'b0, n);
  endtask

  task automatic exp_sat(input string name, input logic [15:0] n,
                         input logic [7:0] s, input logic c, input logic h);
    push(name, K_SAT, s, c, h, n);
  endtask

  // Monitor: outputs are sampled on the falling edge, half a cycle away
  // from the edge that updates them.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      mon_e = exp_q.pop_front();
      if (mon_e.cyc != cyc) begin
        check({mon_e.name, ".stale"}, 16'(cyc), 16'(mon_e.cyc));
      end else begin
        case (mon_e.kind)
          K_OUT: begin
            check({mon_e.name, ".stall_out"},  16'(stall_out),  16'(mon_e.stall));
            check({mon_e.name, ".clear_out"},  16'(clear_out),  16'(mon_e.clear));
            check({mon_e.name, ".fetch_hold"}, 16'(fetch_hold), 16'(mon_e.hold));
          end
          K_CNT: check({mon_e.name, ".stall_count"}, stall_count, mon_e.cnt);
          default: begin
            check({mon_e.name, ".sat_count"},      16'(sat_count),      mon_e.cnt);
            check({mon_e.name, ".sat_stall_out"},  16'(sat_stall_out),  16'(mon_e.stall));
            check({mon_e.name, ".sat_clear_out"},  16'(sat_clear_out),  16'(mon_e.clear));
            check({mon_e.name, ".sat_fetch_hold"}, 16'(sat_fetch_hold), 16'(mon_e.hold));
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    dec_valid   = 1'b0;
    dec_src_a   = 3'd0;
    dec_src_b   = 3'd0;
    dec_use_a   = 1'b0;
    dec_use_b   = 1'b0;
    dec_dst     = 3'd0;
    dec_dst_wr  = 1'b0;
    dec_is_load = 1'b0;
    br_taken    = 1'b0;
    slp         = 1'b0;
    wake        = 1'b0;
    mem_busy    = 1'b0;
  endtask

  task automatic dec(input logic [2:0] sa, input logic ua,
                     input logic [2:0] sb, input logic ub,
                     input logic [2:0] d, input logic wr, input logic ld);
    dec_valid   = 1'b1;
    dec_src_a   = sa;
    dec_use_a   = ua;
    dec_src_b   = sb;
    dec_use_b   = ub;
    dec_dst     = d;
    dec_dst_wr  = wr;
    dec_is_load = ld;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Hard time bound in case the clock or a process stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------
  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();

    // Reset overrides branch, sleep and an issue attempt in its cycle.
    rst = 1'b1;
    br_taken = 1'b1;
    slp = 1'b1;
    mem_busy = 1'b1;
    dec(3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0);
    tick();
    rst = 1'b0;
    idle(); mem_busy = 1'b1;
    exp_out("rst_hold", 8'h08, 1'b0, 1'b1); exp_cnt("rst_hold", 16'd0);
    tick();
    idle(); dec(3'd3, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    exp_out("rst_no_issue", 8'h00, 1'b0, 1'b0); exp_cnt("rst_busy_cnt", 16'd1);
    tick();

    // RAW: R3 written by a non-load, then read next cycle.
    do_reset();
    dec(3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0);
    exp_out("raw_issue", 8'h00, 1'b0, 1'b0); exp_cnt("raw_c0", 16'd0);
    tick();
    dec(3'd3, 1'b1, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0);
    exp_out("raw_stall1", 8'h01, 1'b0, 1'b1); exp_cnt("raw_c1", 16'd0);
    tick();
    dec(3'd3, 1'b1, 3'd0, 1'b0, 3'd7, 1'b1, 1'b0);
    exp_out("raw_stall2", 8'h01, 1'b0, 1'b1); exp_cnt("raw_c2", 16'd1);
    tick();
    dec(3'd3, 1'b1, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0);
    exp_out("raw_release", 8'h00, 1'b0, 1'b0); exp_cnt("raw_c3", 16'd2);
    tick();
    // R7 was only presented while stalled; R6 is in flight but src_b unused.
    dec(3'd7, 1'b1, 3'd6, 1'b0, 3'd0, 1'b0, 1'b0);
    exp_out("raw_no_stalled_issue", 8'h00, 1'b0, 1'b0);
    tick();
    dec(3'd0, 1'b0, 3'd6, 1'b1, 3'd0, 1'b0, 1'b0);
    exp_out("raw_entry1_srcb", 8'h01, 1'b0, 1'b1);
    tick();
    dec(3'd0, 1'b0, 3'd6, 1'b1, 3'd0, 1'b0, 1'b0);
    exp_out("raw_entry2_free", 8'h00, 1'b0, 1'b0); exp_cnt("raw_c6", 16'd3);
    tick();

    // Load-use: LD R5, then R5 as both sources; then mixed RAW + load-use.
    do_reset();
    dec(3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b1);
    exp_out("lu_issue", 8'h00, 1'b0, 1'b0);
    tick();
    dec(3'd5, 1'b1, 3'd5, 1'b1, 3'd0, 1'b0, 1'b0);
    exp_out("lu_stall1", 8'h02, 1'b0, 1'b1);
    tick();
    exp_out("lu_stall2", 8'h02, 1'b0, 1'b1);
    tick();
    exp_out("lu_release", 8'h00, 1'b0, 1'b0); exp_cnt("lu_c3", 16'd2);
    tick();
    dec(3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1);
    exp_out("mix_ld_r2", 8'h00, 1'b0, 1'b0);
    tick();
    dec(3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0);
    exp_out("mix_add_r1", 8'h00, 1'b0, 1'b0);
    tick();
    dec(3'd1, 1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 1'b0);
    exp_out("mix_both", 8'h03, 1'b0, 1'b1);
    tick();
    exp_out("mix_raw_only", 8'h01, 1'b0, 1'b1); exp_cnt("mix_c7", 16'd3);
    tick();
    exp_out("mix_clear", 8'h00, 1'b0, 1'b0); exp_cnt("mix_c8", 16'd4);
    tick();

    // Branch at N, again at N+2: clear_out N+1..N+4, hazards masked.
    do_reset();
    dec(3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0);
    br_taken = 1'b1;
    exp_out("br_n", 8'h00, 1'b0, 1'b0);
    tick();
    br_taken = 1'b0;
    dec(3'd3, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0);
    exp_out("br_n1_masked", 8'h00, 1'b1, 1'b0);
    tick();
    br_taken = 1'b1; slp = 1'b1;
    exp_out("br_n2_rebranch", 8'h00, 1'b1, 1'b0);
    tick();
    br_taken = 1'b0; slp = 1'b0; mem_busy = 1'b1;
    exp_out("br_n3_busy", 8'h08, 1'b1, 1'b0);
    tick();
    mem_busy = 1'b0;
    exp_out("br_n4", 8'h00, 1'b1, 1'b0);
    tick();
    dec(3'd4, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    exp_out("br_done_no_issue", 8'h00, 1'b0, 1'b0); exp_cnt("br_cnt", 16'd1);
    tick();

    // Sleep: slp pulse, wake at cycle 10, then coincident slp+wake.
    do_reset();
    slp = 1'b1;
    exp_out("slp_pulse", 8'h00, 1'b0, 1'b0);
    tick();
    for (int k = 1; k <= 9; k++) begin
      idle();
      exp_out("sleeping", 8'h04, 1'b0, 1'b1);
      exp_cnt("sleeping", 16'(k - 1));
      tick();
    end
    wake = 1'b1;
    exp_out("wake_c10", 8'h04, 1'b0, 1'b1); exp_cnt("wake_c10", 16'd9);
    tick();
    idle();
    exp_out("awake_c11", 8'h00, 1'b0, 1'b0); exp_cnt("awake_c11", 16'd10);
    tick();
    slp = 1'b1; wake = 1'b1;
    exp_out("slp_wake_same", 8'h00, 1'b0, 1'b0);
    tick();
    idle();
    exp_out("never_slept1", 8'h00, 1'b0, 1'b0);
    tick();
    exp_out("never_slept2", 8'h00, 1'b0, 1'b0); exp_cnt("never_slept", 16'd10);
    tick();

    // Counter saturation: 20 busy cycles.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      idle(); mem_busy = 1'b1;
      exp_out("busy", 8'h08, 1'b0, 1'b1);
      exp_sat("busy", (k > 15) ? 16'd15 : 16'(k), 8'h08, 1'b0, 1'b1);
      tick();
    end
    idle();
    exp_cnt("busy_wide", 16'd20);
    exp_sat("busy_saturated", 16'd15, 8'h00, 1'b0, 1'b0);
    tick();

    // Reset during FL1 while asleep.
    do_reset();
    slp = 1'b1;
    tick();
    idle(); br_taken = 1'b1;
    exp_out("rs_sleeping", 8'h04, 1'b0, 1'b1);
    tick();
    idle(); rst = 1'b1;
    exp_out("rs_fl1_sleep", 8'h04, 1'b1, 1'b0); exp_cnt("rs_fl1_sleep", 16'd1);
    tick();
    rst = 1'b0;
    exp_out("rs_after", 8'h00, 1'b0, 1'b0); exp_cnt("rs_after", 16'd0);
    exp_sat("rs_after", 16'd0, 8'h00, 1'b0, 1'b0);
    tick();

    @(negedge clk);
    #1;
    check("queue_drain", 16'(exp_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 SHALL have parameter SB_DEPTH, default 3, meaning scoreboard entries, one per stage: execute [0], memory access [1], writeback [2].
REQ-002 SHALL have parameter CNT_W, default 16, meaning stall-counter width.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port dec_valid  in  1  decode stage holds a valid instruction.
REQ-006 SHALL have ports dec_src_a / dec_src_b  in  3 each  decode source register numbers.
REQ-007 SHALL have ports dec_use_a / dec_use_b  in  1 each  corresponding source is a register read, not a constant.
REQ-008 SHALL have port dec_dst  in  3  decode destination register.
REQ-009 SHALL have port dec_dst_wr  in  1  instruction writes dec_dst.
REQ-010 SHALL have port dec_is_load  in  1  result available only after memory access (LD/LDR).
REQ-011 SHALL have port br_taken  in  1  execute-stage branch resolved taken.
REQ-012 SHALL have port slp  in  1  SLP instruction in execute.
REQ-013 SHALL have port wake  in  1  wake/interrupt request.
REQ-014 SHALL have port mem_busy  in  1  data memory not ready.
REQ-015 SHALL have port stall_out  out  8  per-cause stall vector, consumed as the pipeline registers' stall_in.
REQ-016 SHALL have port clear_out  out  1  flush request, consumed as clear_in.
REQ-017 SHALL have port fetch_hold  out  1  freeze PC/fetch.
REQ-018 SHALL have port stall_count  out  CNT_W  cycles with any stall.

Function
REQ-019 SHALL keep SB_DEPTH scoreboard entries {valid, dst[2:0], is_load}, shifting [i]->[i+1] every cycle unconditionally; entry [SB_DEPTH-1] is discarded.
REQ-020 SHALL load entry [0] with {1, dec_dst, dec_is_load} when issue = dec_valid & dec_dst_wr & ~|stall_out & ~clear_out; otherwise load a bubble (valid=0).
REQ-021 SHALL define match(x) as dec_valid & use_x & valid[i] & dst[i]==src_x for i in {0,1}; entry [2] never causes a hazard, since its write lands on the issuing edge.
REQ-022 SHALL drive stall_out[0] (RAW) combinationally when match on a non-load entry, and stall_out[1] (load-use) when match on a load entry; both may be high together.
REQ-023 SHALL drive stall_out[2] = sleep state is SLEEP; stall_out[3] = mem_busy; stall_out[7:4] = 0.
REQ-024 SHALL force stall_out[1:0] to 0 while clear_out=1; clear overrides hazards.
REQ-025 SHALL implement flush FSM IDLE->FL1->FL2->IDLE, with clear_out=1 in FL1 and FL2, so the flush lasts exactly 2 cycles.
REQ-026 SHALL enter FL1 from any flush state on br_taken, so a branch during a flush restarts the 2-cycle window.
REQ-027 SHALL implement sleep FSM RUN->SLEEP on slp & ~wake & ~clear_out, and SLEEP->RUN on wake; wake takes priority when coincident with slp.
REQ-028 SHALL drive fetch_hold = |stall_out & ~clear_out.
REQ-029 SHALL increment stall_count each cycle |stall_out=1, saturating at all-ones with no wrap.
REQ-030 SHALL add no latency on stall_out/fetch_hold, which are same-cycle combinational from state and inputs; clear_out is registered, 1 cycle after br_taken.

Reset
REQ-031 SHALL, on rst=1 at a posedge, clear all scoreboard valids, flush FSM->IDLE, sleep FSM->RUN, and stall_count=0.
REQ-032 SHALL hold outputs after reset at stall_out=mem_busy<<3, clear_out=0, fetch_hold=mem_busy.
REQ-033 SHALL let rst override every input during its cycle, including an in-progress flush or sleep.

Verification
REQ-034 SHALL cover RAW: issue R3 write (non-load), next cycle decode reads R3 -> stall_out=0x01 for exactly 2 cycles, stall_count=2, then issue.
REQ-035 SHALL cover load-use: LD to R5, next decode reads R5 and R5 as both src_a and src_b -> stall_out=0x02 for 2 cycles.
REQ-036 SHALL cover branch: br_taken at cycle N -> clear_out=1 at N+1, N+2; br_taken again at N+2 -> clear_out extends through N+4; hazards masked throughout.
REQ-037 SHALL cover sleep: slp pulse -> stall_out=0x04 until wake; wake at cycle 10 -> stall_out=0x00 at cycle 11; slp+wake coincident -> never sleeps.
REQ-038 SHALL cover counter saturation and reset: CNT_W=4, 20 stall cycles -> stall_count=0xF; rst mid-FL1 with sleep active -> next cycle all outputs at reset values.
